// File: rtl/alu_seq_muldiv.sv
// Multi-cycle EX-stage ALU: single-cycle logic/arith ops plus shift-add multiply
// and restoring unsigned divide/remainder, all results behind a valid/ready handshake.
module alu_seq_muldiv #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [3:0]      ALUCtl,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ALUOut,
  output logic            Zero,
  output logic            busy
);

  localparam int unsigned CNTW = SHW;
  localparam logic [CNTW-1:0] LAST_ITER = CNTW'(XLEN - 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;
  localparam logic [3:0] OP_MUL  = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1110;
  localparam logic [3:0] OP_REMU = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  // a: multiplicand (MUL) / dividend-shifting-into-quotient (DIV)
  // b: multiplier (MUL) / divisor (DIV)
  // acc: product (MUL) / partial remainder (DIV)
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [3:0]      op_q, op_d;
  logic [XLEN-1:0] alu_out_q, alu_out_d;
  logic            zero_q, zero_d;

  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] sc_res;
  logic [XLEN-1:0] mul_acc;
  logic [XLEN:0]   div_tmp;
  logic [XLEN:0]   div_sub;
  logic            div_ge;
  logic [XLEN-1:0] div_rem;
  logic [XLEN-1:0] div_quo;
  logic            res_load;

  assign shamt     = B[SHW-1:0];
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == MUL) || (state_q == DIV);
  assign ALUOut    = alu_out_q;
  assign Zero      = zero_q;

  // Single-cycle result from the operands presented at the accept edge
  always_comb begin
    sc_res = '0;
    case (ALUCtl)
      OP_ADD:  sc_res = A + B;
      OP_SUB:  sc_res = A - B;
      OP_SLT:  sc_res = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: sc_res = {{(XLEN-1){1'b0}}, (A < B)};
      OP_AND:  sc_res = A & B;
      OP_OR:   sc_res = A | B;
      OP_XOR:  sc_res = A ^ B;
      OP_SLL:  sc_res = A << shamt;
      OP_SRL:  sc_res = A >> shamt;
      OP_SRA:  sc_res = $signed(A) >>> shamt;
      default: sc_res = '0;
    endcase
  end

  // One shift-add step and one restoring-division step
  always_comb begin
    mul_acc = acc_q + (b_q[0] ? a_q : '0);
    div_tmp = {acc_q, a_q[XLEN-1]};
    div_sub = div_tmp - {1'b0, b_q};
    div_ge  = (div_tmp >= {1'b0, b_q});
    div_rem = div_ge ? div_sub[XLEN-1:0] : div_tmp[XLEN-1:0];
    div_quo = {a_q[XLEN-2:0], div_ge};
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    alu_out_d = alu_out_q;
    zero_d    = zero_q;
    res_load  = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d = ALUCtl;
          case (ALUCtl)
            OP_MUL: begin
              a_d     = A;
              b_d     = B;
              acc_d   = '0;
              cnt_d   = '0;
              state_d = MUL;
            end
            OP_DIVU, OP_REMU: begin
              if (B == '0) begin
                alu_out_d = (ALUCtl == OP_DIVU) ? '1 : A;
                res_load  = 1'b1;
                state_d   = DONE;
              end else begin
                a_d     = A;
                b_d     = B;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = DIV;
              end
            end
            default: begin
              alu_out_d = sc_res;
              res_load  = 1'b1;
              state_d   = DONE;
            end
          endcase
        end
      end
      MUL: begin
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        acc_d = mul_acc;
        cnt_d = cnt_q + CNTW'(1);
        if (cnt_q == LAST_ITER) begin
          alu_out_d = mul_acc;
          res_load  = 1'b1;
          state_d   = DONE;
        end
      end
      DIV: begin
        a_d   = div_quo;
        acc_d = div_rem;
        cnt_d = cnt_q + CNTW'(1);
        if (cnt_q == LAST_ITER) begin
          alu_out_d = (op_q == OP_REMU) ? div_rem : div_quo;
          res_load  = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (res_load) zero_d = (alu_out_d == '0);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      op_q      <= '0;
      alu_out_q <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      alu_out_q <= alu_out_d;
      zero_q    <= zero_d;
    end
  end

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Directed bench for alu_seq_muldiv at XLEN=64 and XLEN=32.
module tb_alu_seq_muldiv;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // XLEN=64 instance
  logic        v64, ir64, ov64, or64, z64, busy64;
  logic [63:0] a64, b64, out64;
  logic [3:0]  ctl64;

  // XLEN=32 instance
  logic        v32, ir32, ov32, or32, z32, busy32;
  logic [31:0] a32, b32, out32;
  logic [3:0]  ctl32;

  int n_assert = 0;
  int n_fail   = 0;

  alu_seq_muldiv #(.XLEN(64)) u64 (
    .clk(clk), .rst(rst), .in_valid(v64), .in_ready(ir64), .A(a64), .B(b64),
    .ALUCtl(ctl64), .out_valid(ov64), .out_ready(or64), .ALUOut(out64),
    .Zero(z64), .busy(busy64)
  );

  alu_seq_muldiv #(.XLEN(32)) u32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(ir32), .A(a32), .B(b32),
    .ALUCtl(ctl32), .out_valid(ov32), .out_ready(or32), .ALUOut(out32),
    .Zero(z32), .busy(busy32)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op on the 64-bit DUT; exp_edges counts clock edges after the
  // accept edge until out_valid is seen (0 means visible right after accept).
  task automatic op64(input string tag, input logic [63:0] a, input logic [63:0] b,
                      input logic [3:0] ctl, input logic [63:0] exp_res,
                      input int exp_edges, input int hold);
    int k, nb, nr;
    logic [63:0] held;
    chk({tag, "_in_ready_pre"}, 64'(ir64), 64'd1);
    a64 = a; b64 = b; ctl64 = ctl; v64 = 1'b1;
    @(posedge clk); #1;
    v64 = 1'b0;
    k = 0; nb = 0; nr = 0;
    while (!ov64 && k < 300) begin
      if (busy64) nb++;
      if (ir64) nr++;
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_latency"}, 64'(k), 64'(exp_edges));
    chk({tag, "_busy_cycles"}, 64'(nb), 64'(exp_edges));
    chk({tag, "_in_ready_while_busy"}, 64'(nr), 64'd0);
    chk({tag, "_result"}, out64, exp_res);
    chk({tag, "_zero"}, 64'(z64), 64'(exp_res == 64'd0));
    held = out64;
    for (int h = 0; h < hold; h++) begin
      a64 = {$urandom, $urandom};
      b64 = {$urandom, $urandom};
      ctl64 = 4'($urandom);
      v64 = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_hold_out"}, out64, held);
      chk({tag, "_hold_zero"}, 64'(z64), 64'(held == 64'd0));
      chk({tag, "_hold_valid"}, 64'(ov64), 64'd1);
      chk({tag, "_hold_in_ready"}, 64'(ir64), 64'd0);
    end
    v64 = 1'b0;
    or64 = 1'b1;
    @(posedge clk); #1;
    or64 = 1'b0;
    chk({tag, "_valid_after_take"}, 64'(ov64), 64'd0);
    chk({tag, "_in_ready_after_take"}, 64'(ir64), 64'd1);
  endtask

  task automatic op32(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] ctl, input logic [31:0] exp_res, input int exp_edges);
    int k;
    a32 = a; b32 = b; ctl32 = ctl; v32 = 1'b1;
    @(posedge clk); #1;
    v32 = 1'b0;
    k = 0;
    while (!ov32 && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_latency"}, 64'(k), 64'(exp_edges));
    chk({tag, "_result"}, 64'(out32), 64'(exp_res));
    chk({tag, "_zero"}, 64'(z32), 64'(exp_res == 32'd0));
    or32 = 1'b1;
    @(posedge clk); #1;
    or32 = 1'b0;
    chk({tag, "_in_ready_after_take"}, 64'(ir32), 64'd1);
  endtask

  initial begin
    int nv;
    rst = 1'b1;
    v64 = 1'b0; or64 = 1'b0; a64 = '0; b64 = '0; ctl64 = '0;
    v32 = 1'b0; or32 = 1'b0; a32 = '0; b32 = '0; ctl32 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", 64'(ov64), 64'd0);
    chk("rst_alu_out", out64, 64'd0);
    chk("rst_zero", 64'(z64), 64'd0);
    chk("rst_busy", 64'(busy64), 64'd0);
    chk("rst_in_ready", 64'(ir64), 64'd1);

    // Single-cycle ops
    op64("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, 64'd0, 0, 0);
    op64("sub", 64'd5, 64'd7, 4'b0110, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0);
    op64("sra", 64'h8000_0000_0000_0000, 64'h41, 4'b1010, 64'hC000_0000_0000_0000, 0, 0);
    op64("srl", 64'h8000_0000_0000_0000, 64'h41, 4'b1000, 64'h4000_0000_0000_0000, 0, 0);
    op64("sll", 64'h1, 64'h44, 4'b0011, 64'h10, 0, 0);
    op64("slt", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0100, 64'd1, 0, 0);
    op64("sltu", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b1011, 64'd0, 0, 0);
    op64("xor", 64'hF0F0, 64'hFF00, 4'b0111, 64'h0FF0, 0, 0);
    op64("undef", 64'd123, 64'd456, 4'b0101, 64'd0, 0, 0);

    // Multi-cycle ops
    op64("mul", 64'h1_0000_0001, 64'h1_0000_0003, 4'b1100, 64'h4_0000_0003, 64, 0);
    op64("divu", 64'd100, 64'd7, 4'b1110, 64'd14, 64, 5);
    op64("remu", 64'd100, 64'd7, 4'b1111, 64'd2, 64, 0);
    op64("divu_by0", 64'd5, 64'd0, 4'b1110, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    op64("remu_by0", 64'd5, 64'd0, 4'b1111, 64'd5, 0, 0);

    // Reset in the middle of a multiply
    a64 = 64'd3; b64 = 64'd4; ctl64 = 4'b1100; v64 = 1'b1;
    @(posedge clk); #1;
    v64 = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", 64'(ov64), 64'd0);
    chk("midrst_alu_out", out64, 64'd0);
    chk("midrst_in_ready", 64'(ir64), 64'd1);
    chk("midrst_busy", 64'(busy64), 64'd0);
    nv = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (ov64) nv++;
    end
    chk("midrst_no_stale", 64'(nv), 64'd0);

    // XLEN=32 instance
    op32("x32_mul", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1100, 32'h0000_0001, 32);
    op32("x32_sll", 32'h1, 32'h21, 4'b0011, 32'h2, 0);
    op32("x32_undef", 32'h55, 32'h66, 4'b0101, 32'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
